// File: rtl/reg_dump_uart.sv
// reg_dump_uart: snapshots the fetch PC and R0-R15 through the register-file
// debug port and streams them as uppercase ASCII hex over an 8N1 UART line.
module reg_dump_uart #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] fetchPC,
    input  logic [31:0] debug_reg_out,
    output logic [3:0]  debug_reg_select,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_EARLY = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BAUD_W-1:0] BAUD_ONE   = BAUD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_LATCH  = 3'd2,
        S_SEND   = 3'd3,
        S_TX     = 3'd4
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [BAUD_W-1:0]   baud_cnt_r;
    logic [3:0]          bit_cnt_r;
    logic [3:0]          char_idx_r;
    logic [4:0]          reg_cnt_r;
    logic [31:0]         word_r;
    logic [8:0]          shift_r;

    logic                last_word_s;
    logic [3:0]          char_count_s;
    logic                chars_left_s;
    logic                bit_end_s;
    logic                stop_early_s;
    logic                finish_s;
    logic [31:0]         word_shifted_s;
    logic [7:0]          next_byte_s;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

    // Word/character bookkeeping and selection of the next byte to send.
    always_comb begin
        last_word_s    = (reg_cnt_r == 5'd16);
        char_count_s   = last_word_s ? 4'd10 : 4'd9;
        chars_left_s   = (char_idx_r < char_count_s);
        bit_end_s      = (baud_cnt_r == BAUD_LAST);
        stop_early_s   = (bit_cnt_r == 4'd9) && (baud_cnt_r == BAUD_EARLY);
        finish_s       = (state_r == S_TX) && (bit_cnt_r == 4'd9) && bit_end_s;
        word_shifted_s = word_r << {char_idx_r[2:0], 2'b00};
        next_byte_s    = 8'h20;
        case (char_idx_r)
            4'd8:    next_byte_s = last_word_s ? 8'h0D : 8'h20;
            4'd9:    next_byte_s = 8'h0A;
            default: begin
                if (char_idx_r < 4'd8) begin
                    next_byte_s = hex_ascii(word_shifted_s[31:28]);
                end else begin
                    next_byte_s = 8'h20;
                end
            end
        endcase
    end

    // Next-state logic; leaving TX one cycle before the stop bit ends lets
    // SEND/SELECT overlap the final stop-bit cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_SEND;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_SELECT: next_state_s = S_LATCH;
            S_LATCH:  next_state_s = S_SEND;
            S_SEND:   next_state_s = S_TX;
            S_TX: begin
                if (stop_early_s && chars_left_s) begin
                    next_state_s = S_SEND;
                end else if (stop_early_s && !last_word_s) begin
                    next_state_s = S_SELECT;
                end else if (finish_s) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_TX;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath: snapshot, register stepping, UART shifter and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt_r       <= '0;
            bit_cnt_r        <= 4'd0;
            char_idx_r       <= 4'd0;
            reg_cnt_r        <= 5'd0;
            word_r           <= 32'h0;
            shift_r          <= 9'h1FF;
            debug_reg_select <= 4'd0;
            tx               <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (start) begin
                        word_r     <= fetchPC;
                        char_idx_r <= 4'd0;
                        reg_cnt_r  <= 5'd0;
                        busy       <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_SELECT: begin
                    debug_reg_select <= reg_cnt_r[3:0];
                end
                S_LATCH: begin
                    word_r     <= debug_reg_out;
                    reg_cnt_r  <= reg_cnt_r + 5'd1;
                    char_idx_r <= 4'd0;
                end
                S_SEND: begin
                    shift_r    <= {1'b1, next_byte_s};
                    tx         <= 1'b0;
                    baud_cnt_r <= '0;
                    bit_cnt_r  <= 4'd0;
                    char_idx_r <= char_idx_r + 4'd1;
                end
                S_TX: begin
                    if (finish_s) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else if (bit_end_s) begin
                        baud_cnt_r <= '0;
                        bit_cnt_r  <= bit_cnt_r + 4'd1;
                        tx         <= shift_r[0];
                        shift_r    <= {1'b1, shift_r[8:1]};
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                default: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_uart.sv
// Self-checking bench for reg_dump_uart: a reference model builds the expected
// byte stream and per-cycle tx waveform from the register values.
module tb_reg_dump_uart;

    localparam int CPB         = 4;
    localparam int BUSY_CYCLES = 1540 * CPB + 33;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b0;
    logic [31:0] fetchPC = 32'h0;
    logic [31:0] debug_reg_out;
    logic [3:0]  debug_reg_select;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] regs [16];
    int          checks   = 0;
    int          failures = 0;

    logic        exp_tx[$];
    logic [7:0]  exp_bytes[$];
    int          byte_start[$];
    int          latch_pos[$];
    logic        got_tx[$];
    logic [7:0]  dec[$];
    logic [3:0]  sel_log[$];

    reg_dump_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .fetchPC          (fetchPC),
        .debug_reg_out    (debug_reg_out),
        .debug_reg_select (debug_reg_select),
        .tx               (tx),
        .busy             (busy),
        .done             (done)
    );

    assign debug_reg_out = regs[debug_reg_select];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
    endfunction

    task automatic push_byte(input logic [7:0] b);
        exp_bytes.push_back(b);
        byte_start.push_back(exp_tx.size());
        repeat (CPB) exp_tx.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (CPB) exp_tx.push_back(b[i]);
        repeat (CPB) exp_tx.push_back(1'b1);
    endtask

    task automatic build_expected(input logic [31:0] pc);
        exp_tx.delete();
        exp_bytes.delete();
        byte_start.delete();
        latch_pos.delete();
        for (int w = 0; w < 17; w++) begin
            logic [31:0] v;
            v = (w == 0) ? pc : regs[w-1];
            if (w > 0) begin
                exp_tx.push_back(1'b1);
                exp_tx.push_back(1'b1);
                latch_pos.push_back(exp_tx.size() - 1);
            end
            for (int i = 0; i < 8; i++) push_byte(hex_char(v[31-4*i -: 4]));
            if (w == 16) begin
                push_byte(8'h0D);
                push_byte(8'h0A);
            end else begin
                push_byte(8'h20);
            end
        end
    endtask

    task automatic decode_stream();
        int i;
        logic [7:0] v;
        dec.delete();
        i = 0;
        while (i < got_tx.size()) begin
            if (got_tx[i] === 1'b0 && (i + 10 * CPB - 1) < got_tx.size()) begin
                for (int b = 0; b < 8; b++) v[b] = got_tx[i + CPB * (b + 1) + CPB / 2];
                dec.push_back(v);
                i += 10 * CPB;
            end else begin
                i++;
            end
        end
    endtask

    function automatic logic [63:0] pack8(input int first);
        logic [63:0] r;
        r = 64'h0;
        for (int j = 0; j < 8; j++) begin
            if (first + j < dec.size()) r = {r[55:0], dec[first + j]};
            else r = {r[55:0], 8'h00};
        end
        return r;
    endfunction

    // mode 0: plain dump, 1: stray start pulses mid-frame and at the done edge,
    // 2: reset asserted during the R5 data bits.
    task automatic run_dump(input logic [31:0] pc, input int mode, input string tag);
        int busy_cnt;
        int done_cnt;
        int lp;
        int bad;
        int reset_at;
        got_tx.delete();
        sel_log.delete();
        build_expected(pc);
        reset_at = byte_start[9 * 6 + 2] + 3 * CPB + 1;
        fetchPC = pc;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        fetchPC = ~pc;
        check($sformatf("%s_busy_rise", tag), 64'(busy), 64'd1);
        check($sformatf("%s_tx_send", tag), 64'(tx), 64'd1);
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        done_cnt = (done === 1'b1) ? 1 : 0;
        lp = 0;
        for (int n = 0; n < exp_tx.size(); n++) begin
            if (mode == 1 && n == 2000) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            got_tx.push_back(tx);
            busy_cnt += (busy === 1'b1) ? 1 : 0;
            done_cnt += (done === 1'b1) ? 1 : 0;
            if (lp < latch_pos.size() && n == latch_pos[lp]) begin
                sel_log.push_back(debug_reg_select);
                lp++;
            end
            if (mode == 2 && n == reset_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                check($sformatf("%s_after_reset", tag), {61'h0, tx, busy, done}, 64'b100);
                bad = 0;
                repeat (40) begin
                    @(posedge clk); #1;
                    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
                end
                check($sformatf("%s_stays_idle", tag), 64'(bad), 64'd0);
                return;
            end
        end
        if (mode == 1) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("%s_done_edge", tag), {62'h0, busy, done}, 64'b01);
        check($sformatf("%s_busy_cycles", tag), 64'(busy_cnt), 64'(BUSY_CYCLES));
        check($sformatf("%s_early_done", tag), 64'(done_cnt), 64'd0);
        bad = 0;
        for (int n = 0; n < exp_tx.size(); n++) if (got_tx[n] !== exp_tx[n]) bad++;
        check($sformatf("%s_tx_wave_errs", tag), 64'(bad), 64'd0);
        decode_stream();
        check($sformatf("%s_byte_count", tag), 64'(dec.size()), 64'd154);
        bad = 0;
        for (int j = 0; j < exp_bytes.size(); j++) begin
            if (j >= dec.size() || dec[j] !== exp_bytes[j]) bad++;
        end
        check($sformatf("%s_byte_errs", tag), 64'(bad), 64'd0);
        bad = 0;
        for (int j = 0; j < 16; j++) begin
            if (j >= sel_log.size() || sel_log[j] !== 4'(j)) bad++;
        end
        check($sformatf("%s_select_order", tag), 64'(bad), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'h0;
        reset = 1'b1;
        start = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("reset_state", {57'h0, tx, busy, done, debug_reg_select}, 64'b1000000);
        end
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", {61'h0, tx, busy, done}, 64'b100);

        for (int i = 0; i < 16; i++) regs[i] = 32'h100 + 32'(i);
        run_dump(32'h0000_0040, 0, "basic");
        check("basic_pc_text", pack8(0), 64'h3030303030303430);
        check("basic_r15_text", pack8(9 * 16), 64'h3030303030313046);
        check("basic_crlf", {48'h0, (dec.size() >= 154) ? {dec[152], dec[153]} : 16'h0}, 64'h0D0A);

        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        regs[3] = 32'hDEAD_BEEF;
        regs[7] = 32'h0A1B_2C3F;
        run_dump($urandom, 1, "hex");
        check("hex_r3_bytes", pack8(9 * 4), 64'h4445414442454546);
        check("hex_r7_bytes", pack8(9 * 8), 64'h3041314232433346);
        @(posedge clk); #1;
        check("no_second_dump", 64'(busy), 64'd0);

        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        run_dump($urandom, 2, "rstmid");

        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        run_dump($urandom, 0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
